// File: rtl/psola_pkg.sv
// Shared types and constants for the PSOLA sequencer: FSM state encoding,
// output sample fixed-point format and the default analysis window size.
package psola_pkg;

  localparam int FRAC_BITS           = 10;
  localparam int DEFAULT_WINDOW_SIZE = 2048;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    BUSY,
    SWAP
  } seq_state_t;

endpackage

// File: rtl/psola_sequencer_pipeline.sv
// Fixed-depth delay line: output equals input STAGES cycles earlier.
// No flow control; async reset clears every stage so nothing in flight survives.
module psola_sequencer_pipeline #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/psola_sequencer.sv
// Double-buffered capture/dispatch/playback sequencer around a PSOLA core; audio out 2 cycles after each sample strobe.
// No backpressure: windows completing while the core is busy are dropped with an overrun pulse (PSOLA_SEQ_OVERRUN_CNT_EN adds a counter).
module psola_sequencer
  import psola_pkg::*;
#(
  parameter  int WINDOW_SIZE = DEFAULT_WINDOW_SIZE,
  parameter  int SAMPLE_W    = 16,
  localparam int LW          = $clog2(WINDOW_SIZE)
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                period_valid,
  input  logic [11:0]         period_in,
  output logic                in_wr_en,
  output logic [LW:0]         in_wr_addr,
  output logic [31:0]         in_wr_data,
  output logic                psola_start,
  output logic [11:0]         psola_period,
  output logic                psola_bank,
  input  logic                psola_done,
  input  logic [11:0]         psola_len,
  output logic [LW:0]         out_rd_addr,
  input  logic [31:0]         out_rd_data,
  output logic [SAMPLE_W-1:0] audio_out,
  output logic                audio_out_valid,
  output logic                overrun
`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
  ,
  output logic [15:0]         overrun_count
`endif
);

  localparam int SAT_MAX = (1 << (SAMPLE_W - 1)) - 1;
  localparam int SAT_MIN = -(1 << (SAMPLE_W - 1));

  logic [LW-1:0] cap_ptr;
  logic          cap_bank;
  logic          done_bank;
  logic          window_ready;
  logic [11:0]   period_q;

  seq_state_t    state, state_nx;
  logic          pending, pending_nx;
  logic          do_swap;
  logic          period_ok;

  logic [LW-1:0] play_ptr;
  logic          play_bank;
  logic [11:0]   play_len;
  logic [11:0]   len_q;

  logic          rd_vld;
  logic          rd_mute;
  logic signed [31:0] shifted;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      in_wr_en     <= 1'b0;
      in_wr_addr   <= '0;
      in_wr_data   <= '0;
      cap_ptr      <= '0;
      cap_bank     <= 1'b0;
      done_bank    <= 1'b0;
      window_ready <= 1'b0;
      period_q     <= '0;
    end else begin
      in_wr_en     <= sample_valid;
      window_ready <= 1'b0;
      if (period_valid) period_q <= period_in;
      if (sample_valid) begin
        in_wr_addr <= {cap_bank, cap_ptr};
        in_wr_data <= {{(32-SAMPLE_W){sample_in[SAMPLE_W-1]}}, sample_in};
        cap_ptr    <= cap_ptr + LW'(1);
        if (&cap_ptr) begin
          cap_bank     <= ~cap_bank;
          done_bank    <= cap_bank;
          window_ready <= 1'b1;
        end
      end
    end
  end

  // Unvoiced windows (no usable pitch) are not worth sending to the core.
  assign period_ok = (period_q != '0) && (32'(period_q) < WINDOW_SIZE / 2);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      pending <= 1'b0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    pending_nx   = pending;
    psola_start  = 1'b0;
    psola_period = '0;
    psola_bank   = 1'b0;
    overrun      = 1'b0;
    do_swap      = 1'b0;
    case (state)
      IDLE: if (window_ready) state_nx = DISPATCH;
      DISPATCH: begin
        pending_nx = 1'b0;
        if (period_ok) begin
          psola_start  = 1'b1;
          psola_period = period_q;
          psola_bank   = done_bank;
          state_nx     = BUSY;
        end else begin
          state_nx = IDLE;
        end
      end
      BUSY: begin
        if (psola_done) begin
          state_nx   = SWAP;
          pending_nx = window_ready;
        end else if (window_ready) begin
          overrun = 1'b1;
        end
      end
      SWAP: begin
        do_swap    = 1'b1;
        pending_nx = 1'b0;
        state_nx   = (pending || window_ready) ? DISPATCH : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      play_ptr  <= '0;
      play_bank <= 1'b0;
      play_len  <= '0;
      len_q     <= '0;
    end else begin
      if (state == BUSY && psola_done) len_q <= psola_len;
      if (do_swap) begin
        play_len  <= len_q;
        play_bank <= ~play_bank;
        play_ptr  <= '0;
      end else if (sample_valid) begin
        play_ptr <= (32'(play_ptr) + 32'd1 >= 32'(play_len)) ? '0 : play_ptr + LW'(1);
      end
    end
  end

  assign out_rd_addr = {play_bank, play_ptr};

  psola_sequencer_pipeline #(.STAGES(2), .WIDTH(1)) u_vld_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (sample_valid),
    .q      (rd_vld)
  );

  // Mute travels with the read so a len change mid-flight cannot affect it.
  psola_sequencer_pipeline #(.STAGES(2), .WIDTH(1)) u_mute_pipe (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .d      (play_len == '0),
    .q      (rd_mute)
  );

  assign shifted         = $signed(out_rd_data) >>> FRAC_BITS;
  assign audio_out_valid = rd_vld;

  always_comb begin
    audio_out = '0;
    if (rd_vld && !rd_mute) begin
      if (shifted > SAT_MAX)      audio_out = SAMPLE_W'(SAT_MAX);
      else if (shifted < SAT_MIN) audio_out = SAMPLE_W'(SAT_MIN);
      else                        audio_out = shifted[SAMPLE_W-1:0];
    end
  end

`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)                          overrun_count <= '0;
    else if (overrun && ~&overrun_count) overrun_count <= overrun_count + 16'd1;
  end
`else
  // overrun pulse is the only drop indication in this build.
`endif

endmodule

// File: tb/tb_psola_sequencer.sv
// Randomized bench for psola_sequencer: abstract window/playback model feeds
// expectation queues that a negedge monitor drains as the DUT produces output.
module tb_psola_sequencer;

  localparam int W  = 2048;
  localparam int LW = 11;
  localparam int SW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample_in = '0;
  logic          period_valid = 1'b0;
  logic [11:0]   period_in = '0;
  logic          in_wr_en;
  logic [LW:0]   in_wr_addr;
  logic [31:0]   in_wr_data;
  logic          psola_start;
  logic [11:0]   psola_period;
  logic          psola_bank;
  logic          psola_done = 1'b0;
  logic [11:0]   psola_len = '0;
  logic [LW:0]   out_rd_addr;
  logic [31:0]   out_rd_data;
  logic [SW-1:0] audio_out;
  logic          audio_out_valid;
  logic          overrun;
`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
  logic [15:0]   overrun_count;
`endif

  psola_sequencer #(.WINDOW_SIZE(W), .SAMPLE_W(SW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid    (sample_valid),
    .sample_in       (sample_in),
    .period_valid    (period_valid),
    .period_in       (period_in),
    .in_wr_en        (in_wr_en),
    .in_wr_addr      (in_wr_addr),
    .in_wr_data      (in_wr_data),
    .psola_start     (psola_start),
    .psola_period    (psola_period),
    .psola_bank      (psola_bank),
    .psola_done      (psola_done),
    .psola_len       (psola_len),
    .out_rd_addr     (out_rd_addr),
    .out_rd_data     (out_rd_data),
    .audio_out       (audio_out),
    .audio_out_valid (audio_out_valid),
    .overrun         (overrun)
`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
    ,
    .overrun_count   (overrun_count)
`endif
  );

  always #5 clk_in = ~clk_in;

  // Output BRAM: two-cycle read latency, carrying the address along for checking.
  logic [31:0] mem [0:2*W-1];
  logic [31:0] rd_d1 = '0, rd_d2 = '0;
  logic [LW:0] rd_a1 = '0, rd_a2 = '0;
  always @(posedge clk_in) begin
    rd_d1 <= mem[out_rd_addr];
    rd_a1 <= out_rd_addr;
    rd_d2 <= rd_d1;
    rd_a2 <= rd_a1;
  end
  assign out_rd_data = rd_d2;

  typedef struct { logic [LW:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic [LW:0] addr; logic [SW-1:0] audio; } au_t;
  typedef struct { logic bank; logic [11:0] period; int lat; } st_t;

  wr_t exp_wr_q[$];
  au_t exp_au_q[$];
  st_t exp_st_q[$];
  int  ovr_exp = 0;

  int n_pass = 0, n_total = 0;
  int cyc = 0, last_wr_cyc = 0;

  // Reference model state
  int  n_samp = 0;
  int  period_m = 0;
  bit  core_busy = 0;
  int  play_bank_m = 0, play_len_m = 0, play_cnt = 0;
  int  ovr_cnt_m = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [SW-1:0] sat(input logic [31:0] d);
    int v;
    v = $signed(d) >>> 10;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    return v[SW-1:0];
  endfunction

  wr_t w_m;
  au_t a_m;
  st_t s_m;
  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (in_wr_en) begin
        if (exp_wr_q.size() == 0) check("wr_unexpected", in_wr_en, 0);
        else begin
          w_m = exp_wr_q.pop_front();
          check("wr_addr", in_wr_addr, w_m.addr);
          check("wr_data", in_wr_data, w_m.data);
        end
        if (in_wr_addr[LW-1:0] == LW'(W-1)) last_wr_cyc = cyc;
      end
      if (psola_start) begin
        if (exp_st_q.size() == 0) check("start_unexpected", psola_start, 0);
        else begin
          s_m = exp_st_q.pop_front();
          check("start_bank", psola_bank, s_m.bank);
          check("start_period", psola_period, s_m.period);
          check("start_latency", cyc - last_wr_cyc, s_m.lat);
        end
      end
      if (overrun) begin
        if (ovr_exp == 0) check("overrun_unexpected", overrun, 0);
        else ovr_exp--;
      end
      if (audio_out_valid) begin
        if (exp_au_q.size() == 0) check("audio_unexpected", audio_out_valid, 0);
        else begin
          a_m = exp_au_q.pop_front();
          check("audio_rd_addr", rd_a2, a_m.addr);
          check("audio_out", audio_out, a_m.audio);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_period(input int p);
    period_valid = 1'b1;
    period_in    = 12'(p);
    tick();
    period_valid = 1'b0;
    period_m     = p;
  endtask

  task automatic send_sample(input int gap);
    logic [SW-1:0] s;
    wr_t w;
    au_t a;
    int  idx;
    s      = SW'($urandom);
    w.addr = (LW+1)'(((n_samp / W) % 2) * W + (n_samp % W));
    w.data = 32'(int'($signed(s)));
    exp_wr_q.push_back(w);
    idx     = (play_len_m == 0) ? 0 : play_cnt % play_len_m;
    a.addr  = (LW+1)'(play_bank_m * W + idx);
    a.audio = (play_len_m == 0) ? '0 : sat(mem[a.addr]);
    exp_au_q.push_back(a);
    play_cnt++;
    n_samp++;
    sample_valid = 1'b1;
    sample_in    = s;
    tick();
    sample_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic model_swap(input int len);
    play_bank_m ^= 1;
    play_len_m  = len;
    play_cnt    = 0;
    core_busy   = 0;
  endtask

  task automatic window_end(input int lat);
    st_t s;
    if (core_busy) begin
      ovr_exp++;
      ovr_cnt_m++;
    end else if (period_m != 0 && period_m < W / 2) begin
      s.bank   = 1'(((n_samp - 1) / W) % 2);
      s.period = 12'(period_m);
      s.lat    = lat;
      exp_st_q.push_back(s);
      core_busy = 1;
    end
  endtask

  // Full windows end with a window_end evaluation; coinc pulses done in the window_ready cycle.
  task automatic send_window(input int p, input bit coinc, input int clen, input int nsamp);
    for (int i = 0; i < nsamp; i++) begin
      if (i == 100)  set_period($urandom_range(0, 4095));
      if (i == 1500) set_period(p);
      send_sample((i == nsamp - 1) ? 0 : $urandom_range(0, 1));
    end
    if (nsamp == W) begin
      if (coinc) begin
        psola_done = 1'b1;
        psola_len  = 12'(clen);
        tick();
        psola_done = 1'b0;
        model_swap(clen);
        window_end(2);
      end else begin
        window_end(1);
      end
      repeat (4) tick();
    end
  endtask

  task automatic core_done(input int len);
    repeat (2) tick();
    psola_done = 1'b1;
    psola_len  = 12'(len);
    tick();
    psola_done = 1'b0;
    model_swap(len);
    repeat (3) tick();
  endtask

  task automatic check_outputs_zero();
    check("rst_in_wr_en", in_wr_en, 0);
    check("rst_in_wr_addr", in_wr_addr, 0);
    check("rst_in_wr_data", in_wr_data, 0);
    check("rst_psola_start", psola_start, 0);
    check("rst_psola_period", psola_period, 0);
    check("rst_psola_bank", psola_bank, 0);
    check("rst_out_rd_addr", out_rd_addr, 0);
    check("rst_audio_out", audio_out, 0);
    check("rst_audio_valid", audio_out_valid, 0);
    check("rst_overrun", overrun, 0);
`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
    check("rst_overrun_count", overrun_count, 0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_wr_q.size() == 0 && exp_au_q.size() == 0 && exp_st_q.size() == 0 && ovr_exp == 0) break;
      tick();
    end
    check("wr_left", exp_wr_q.size(), 0);
    check("audio_left", exp_au_q.size(), 0);
    check("start_left", exp_st_q.size(), 0);
    check("overrun_left", ovr_exp, 0);
  endtask

  initial begin
    logic signed [31:0] r;
    for (int i = 0; i < 2 * W; i++) begin
      r = $urandom;
      mem[i] = r >>> $urandom_range(0, 24);
    end
    mem[W + 0] = 32'h7FFF_FFFF;
    mem[W + 1] = 32'h8000_0000;
    mem[W + 2] = 32'h0000_0C00;

    repeat (3) @(posedge clk_in);
    #1;
    check_outputs_zero();
    rst_in = 1'b0;
    repeat (2) tick();

    send_window(200, 0, 0, W);                          // dispatch bank 0, period 200
    send_window($urandom_range(1, 1023), 0, 0, W);      // core busy -> overrun
    core_done(1800);
    send_window($urandom_range(1, 1023), 0, 0, W);      // loops 0..1799, dispatch bank 0
    send_window($urandom_range(1, 1023), 1, 37, W);     // done + window_ready together
    core_done(3);                                       // plays saturation test words
    send_window(0, 0, 0, W);                            // unvoiced: skipped
    send_window(1024, 0, 0, W);                         // too long: skipped
    send_window(1023, 0, 0, W);                         // largest valid period
    core_done(0);
    drain();

`ifdef PSOLA_SEQ_OVERRUN_CNT_EN
    check("overrun_count", overrun_count, ovr_cnt_m);
`endif
    send_window(500, 0, 0, 700);                        // partial window, reads in flight
    rst_in = 1'b1;
    exp_wr_q.delete();
    exp_au_q.delete();
    exp_st_q.delete();
    ovr_exp = 0;
    #1;
    check_outputs_zero();
    n_samp = 0; period_m = 0; core_busy = 0;
    play_bank_m = 0; play_len_m = 0; play_cnt = 0; ovr_cnt_m = 0;
    repeat (3) tick();
    rst_in = 1'b0;
    repeat (2) tick();

    send_window(300, 0, 0, W);                          // restarts at bank 0 address 0
    core_done(5);
    for (int i = 0; i < 20; i++) send_sample($urandom_range(0, 2));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
